// File: rtl/instruction_issuer_if.sv
// Instruction bus between the issuer and the control-unit decoder.
// The issuer presents a 16-bit word with valid/ready; the decoder reports
// completion of the accepted operation on op_done.
interface instruction_issuer_if;
   logic [15:0] instruction;
   logic        instr_valid;
   logic        instr_ready;
   logic        op_done;

   modport master (
      output instruction,
      output instr_valid,
      input  instr_ready,
      input  op_done
   );

   modport slave (
      input  instruction,
      input  instr_valid,
      output instr_ready,
      output op_done
   );
endinterface

// File: rtl/instruction_issuer.sv
// Front-end sequencer: fetches 16-bit words from a synchronous instruction
// memory, issues legal operations to the decoder over a valid/ready bus, waits
// for execution to finish, and stops on HALT, an illegal opcode or overrun.
module instruction_issuer #(
   parameter int ADDR_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [ADDR_W-1:0]    imem_addr,
   output logic                 imem_rd_en,
   input  logic [15:0]          imem_rdata,
   instruction_issuer_if.master bus,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [1:0]           err_code,
   output logic [ADDR_W:0]      instr_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_ISSUE,
      S_EXEC,
      S_DONE,
      S_ERROR
   } state_e;

   localparam logic [1:0]        ERR_NONE    = 2'b00;
   localparam logic [1:0]        ERR_ILLEGAL = 2'b01;
   localparam logic [1:0]        ERR_OVERRUN = 2'b10;
   localparam logic [ADDR_W-1:0] PC_LAST     = '1;
   localparam logic [ADDR_W:0]   COUNT_MAX   = {1'b1, {ADDR_W{1'b0}}};

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       instruction_q, instruction_d;
   logic              instr_valid_q, instr_valid_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [1:0]        err_code_q, err_code_d;
   logic [ADDR_W:0]   instr_count_q, instr_count_d;

   // Next-state and next-register computation for the issue sequencer.
   always_comb begin
      // NOTE: every target gets a default first so no path through the case infers a latch.
      state_d       = state_q;
      pc_d          = pc_q;
      instruction_d = instruction_q;
      instr_valid_d = instr_valid_q;
      done_d        = 1'b0;
      err_d         = err_q;
      err_code_d    = err_code_q;
      instr_count_d = instr_count_q;

      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d       = S_FETCH;
               pc_d          = '0;
               instr_count_d = '0;
               err_d         = 1'b0;
               err_code_d    = ERR_NONE;
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            case (imem_rdata[15:13])
               3'b000, 3'b001, 3'b010, 3'b011: begin
                  instruction_d = imem_rdata;
                  instr_valid_d = 1'b1;
                  state_d       = S_ISSUE;
               end
               3'b111: begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end
               default: begin
                  err_d      = 1'b1;
                  err_code_d = ERR_ILLEGAL;
                  state_d    = S_ERROR;
               end
            endcase
         end
         S_ISSUE: begin
            // op_done is deliberately not looked at here; completion only counts in EXEC.
            if (bus.instr_ready) begin
               instr_valid_d = 1'b0;
               if (instr_count_q != COUNT_MAX) instr_count_d = instr_count_q + 1'b1;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (bus.op_done) begin
               if (pc_q == PC_LAST) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_OVERRUN;
                  state_d    = S_ERROR;
               end else begin
                  pc_d    = pc_q + 1'b1;
                  state_d = S_FETCH;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously by rst.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      if (!rst) begin
         state_q       <= S_IDLE;
         pc_q          <= '0;
         instruction_q <= 16'h0000;
         instr_valid_q <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         err_code_q    <= ERR_NONE;
         instr_count_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instruction_q <= instruction_d;
         instr_valid_q <= instr_valid_d;
         done_q        <= done_d;
         err_q         <= err_d;
         err_code_q    <= err_code_d;
         instr_count_q <= instr_count_d;
      end
   end

   // Memory strobe is decoded from state so the read lands exactly in DECODE.
   assign imem_rd_en      = (state_q == S_FETCH);
   assign imem_addr       = pc_q;
   assign bus.instruction = instruction_q;
   assign bus.instr_valid = instr_valid_q;
   assign busy            = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
   assign done            = done_q;
   assign err             = err_q;
   assign err_code        = err_code_q;
   assign instr_count     = instr_count_q;

endmodule

// File: tb/tb_instruction_issuer.sv
// Directed bench for instruction_issuer: a scoreboard queue holds the words
// expected on the bus, popped at each valid/ready handshake. A second instance
// with ADDR_W=2 exercises the address-overrun stop.
module tb_instruction_issuer;
   localparam int AW_A = 8;
   localparam int AW_B = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst = 1'b1;

   // Instance A (ADDR_W = 8)
   logic              start_a = 1'b0;
   logic [AW_A-1:0]   imem_addr_a;
   logic              imem_rd_en_a;
   logic [15:0]       imem_rdata_a;
   logic              busy_a, done_a, err_a;
   logic [1:0]        err_code_a;
   logic [AW_A:0]     instr_count_a;
   logic [15:0]       mem_a [0:(1<<AW_A)-1];
   instruction_issuer_if bus_a ();

   // Instance B (ADDR_W = 2)
   logic              start_b = 1'b0;
   logic [AW_B-1:0]   imem_addr_b;
   logic              imem_rd_en_b;
   logic [15:0]       imem_rdata_b;
   logic              busy_b, done_b, err_b;
   logic [1:0]        err_code_b;
   logic [AW_B:0]     instr_count_b;
   logic [15:0]       mem_b [0:(1<<AW_B)-1];
   instruction_issuer_if bus_b ();

   // Synchronous memories: data one cycle after the read strobe.
   always @(posedge clk) if (imem_rd_en_a) imem_rdata_a <= mem_a[imem_addr_a];
   always @(posedge clk) if (imem_rd_en_b) imem_rdata_b <= mem_b[imem_addr_b];

   instruction_issuer #(.ADDR_W(AW_A)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a),
      .imem_addr(imem_addr_a), .imem_rd_en(imem_rd_en_a), .imem_rdata(imem_rdata_a),
      .bus(bus_a.master),
      .busy(busy_a), .done(done_a), .err(err_a), .err_code(err_code_a),
      .instr_count(instr_count_a)
   );

   instruction_issuer #(.ADDR_W(AW_B)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b),
      .imem_addr(imem_addr_b), .imem_rd_en(imem_rd_en_b), .imem_rdata(imem_rdata_b),
      .bus(bus_b.master),
      .busy(busy_b), .done(done_b), .err(err_b), .err_code(err_code_b),
      .instr_count(instr_count_b)
   );

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   logic [15:0] exp_a[$];
   logic [15:0] exp_b[$];
   int  acc_a = 0, acc_b = 0;
   int  done_seen_a = 0, done_seen_b = 0;
   int  cnt_a = 0, cnt_b = 0;
   bit  auto_a = 1'b0, auto_b = 1'b0;
   bit  pulse_a = 1'b0, pulse_b = 1'b0;
   int  max_addr_b = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_true(input string tag, input logic cond);
      check(tag, {31'd0, cond}, 32'd1);
   endtask

   // One clock: sample at the falling edge, advance, settle 1 time unit past the rising edge.
   task automatic tick();
      @(negedge clk);
      if (bus_a.instr_valid) begin
         check_true("a_valid_legal_op", bus_a.instruction[15] == 1'b0);
         if (bus_a.instr_ready) begin
            check_true("a_issue_expected", exp_a.size() != 0);
            if (exp_a.size() != 0) check("a_issue_word", bus_a.instruction, exp_a.pop_front());
            acc_a++;
            if (auto_a) cnt_a = 2;
         end
      end
      if (done_a) done_seen_a++;
      if (bus_b.instr_valid && bus_b.instr_ready) begin
         check_true("b_issue_expected", exp_b.size() != 0);
         if (exp_b.size() != 0) check("b_issue_word", bus_b.instruction, exp_b.pop_front());
         acc_b++;
         if (auto_b) cnt_b = 2;
      end
      if (done_b) done_seen_b++;
      if (imem_rd_en_b && int'(imem_addr_b) > max_addr_b) max_addr_b = int'(imem_addr_b);
      @(posedge clk);
      #1;
      if (pulse_a) begin bus_a.op_done = 1'b0; pulse_a = 1'b0; end
      if (cnt_a > 0) begin
         cnt_a--;
         if (cnt_a == 0) begin bus_a.op_done = 1'b1; pulse_a = 1'b1; end
      end
      if (pulse_b) begin bus_b.op_done = 1'b0; pulse_b = 1'b0; end
      if (cnt_b > 0) begin
         cnt_b--;
         if (cnt_b == 0) begin bus_b.op_done = 1'b1; pulse_b = 1'b1; end
      end
   endtask

   task automatic wait_idle_a(input int budget);
      int n = 0;
      while (busy_a && n < budget) begin tick(); n++; end
      check_true("a_idle_timeout", !busy_a);
   endtask

   task automatic wait_valid_a(input int budget);
      int n = 0;
      while (!bus_a.instr_valid && n < budget) begin tick(); n++; end
      check_true("a_valid_timeout", bus_a.instr_valid);
   endtask

   task automatic wait_acc_a(input int target, input int budget);
      int n = 0;
      while (acc_a < target && n < budget) begin tick(); n++; end
      check("a_accept_timeout", acc_a, target);
   endtask

   task automatic wait_idle_b(input int budget);
      int n = 0;
      while (busy_b && n < budget) begin tick(); n++; end
      check_true("b_idle_timeout", !busy_b);
   endtask

   task automatic pulse_start_a();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
   endtask

   task automatic std_prog_a();
      for (int i = 0; i < (1 << AW_A); i++) mem_a[i] = 16'hA000;
      mem_a[0] = 16'h0000;
      mem_a[1] = 16'h2000;
      mem_a[2] = 16'h4000;
      mem_a[3] = 16'h6000;
      mem_a[4] = 16'hE000;
      exp_a.delete();
      exp_a.push_back(16'h0000);
      exp_a.push_back(16'h2000);
      exp_a.push_back(16'h4000);
      exp_a.push_back(16'h6000);
      acc_a       = 0;
      done_seen_a = 0;
   endtask

   initial begin
      bus_a.instr_ready = 1'b0;
      bus_a.op_done     = 1'b0;
      bus_b.instr_ready = 1'b0;
      bus_b.op_done     = 1'b0;
      for (int i = 0; i < (1 << AW_A); i++) mem_a[i] = 16'hA000;
      for (int i = 0; i < (1 << AW_B); i++) mem_b[i] = 16'h4000;

      // Reset values
      #1 rst = 1'b0;
      #2;
      check("rst_instr_valid", bus_a.instr_valid, 0);
      check("rst_instruction", bus_a.instruction, 16'h0000);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_err", err_a, 0);
      check("rst_err_code", err_code_a, 0);
      check("rst_instr_count", instr_count_a, 0);
      check("rst_imem_rd_en", imem_rd_en_a, 0);
      check("rst_imem_addr", imem_addr_a, 0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;

      // Straight-line program with HALT, including start latency
      std_prog_a();
      bus_a.instr_ready = 1'b1;
      auto_a = 1'b1;
      pulse_start_a();
      check("t1_fetch_busy", busy_a, 1);
      check("t1_fetch_rd_en", imem_rd_en_a, 1);
      check("t1_fetch_addr", imem_addr_a, 0);
      tick();
      check("t1_decode_valid", bus_a.instr_valid, 0);
      tick();
      check("t1_latency_start_valid", bus_a.instr_valid, 1);
      check("t1_first_word", bus_a.instruction, 16'h0000);
      wait_idle_a(100);
      tick();
      tick();
      check("t1_scoreboard_empty", exp_a.size(), 0);
      check("t1_accepts", acc_a, 4);
      check("t1_instr_count", instr_count_a, 4);
      check("t1_done_pulses", done_seen_a, 1);
      check("t1_done_low_after", done_a, 0);
      check("t1_err", err_a, 0);
      check("t1_err_code", err_code_a, 0);
      check("t1_busy", busy_a, 0);

      // Decoder stall on the second instruction
      std_prog_a();
      pulse_start_a();
      wait_acc_a(1, 50);
      bus_a.instr_ready = 1'b0;
      wait_valid_a(20);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("t2_stall_valid", bus_a.instr_valid, 1);
         check("t2_stall_word", bus_a.instruction, 16'h2000);
      end
      check("t2_stall_count", instr_count_a, 1);
      bus_a.instr_ready = 1'b1;
      wait_idle_a(100);
      tick();
      check("t2_scoreboard_empty", exp_a.size(), 0);
      check("t2_count_matches_accepts", instr_count_a, acc_a);
      check("t2_instr_count", instr_count_a, 4);

      // Illegal opcode stops in ERROR, then a new start reruns cleanly
      std_prog_a();
      mem_a[1] = 16'h8000;
      exp_a.delete();
      exp_a.push_back(16'h0000);
      pulse_start_a();
      wait_idle_a(100);
      check("t3_err", err_a, 1);
      check("t3_err_code", err_code_a, 2'b01);
      check("t3_instr_count", instr_count_a, 1);
      check("t3_instruction_kept", bus_a.instruction, 16'h0000);
      for (int i = 0; i < 4; i++) tick();
      check("t3_scoreboard_empty", exp_a.size(), 0);
      check("t3_hold_err", err_a, 1);
      check("t3_hold_err_code", err_code_a, 2'b01);
      check("t3_hold_busy", busy_a, 0);
      check("t3_no_done", done_seen_a, 0);
      std_prog_a();
      pulse_start_a();
      check("t3_restart_err_cleared", err_a, 0);
      check("t3_restart_code_cleared", err_code_a, 0);
      check("t3_restart_count_cleared", instr_count_a, 0);
      check("t3_restart_addr", imem_addr_a, 0);
      wait_idle_a(100);
      tick();
      check("t3_rerun_count", instr_count_a, 4);
      check("t3_rerun_done", done_seen_a, 1);

      // op_done during ISSUE and at the handshake, start while busy
      std_prog_a();
      auto_a = 1'b0;
      bus_a.instr_ready = 1'b0;
      bus_a.op_done = 1'b1;
      pulse_start_a();
      wait_valid_a(20);
      tick();
      tick();
      check("t5_issue_hold_valid", bus_a.instr_valid, 1);
      check("t5_issue_hold_count", instr_count_a, 0);
      bus_a.instr_ready = 1'b1;
      tick();
      bus_a.instr_ready = 1'b0;
      bus_a.op_done = 1'b0;
      check("t5_accepted_valid", bus_a.instr_valid, 0);
      check("t5_accepted_count", instr_count_a, 1);
      for (int i = 0; i < 3; i++) tick();
      check("t5_exec_wait_rd_en", imem_rd_en_a, 0);
      check("t5_exec_wait_busy", busy_a, 1);
      pulse_start_a();
      check("t5_busy_start_err", err_a, 0);
      check("t5_busy_start_count", instr_count_a, 1);
      check("t5_busy_start_rd_en", imem_rd_en_a, 0);
      bus_a.op_done = 1'b1;
      tick();
      bus_a.op_done = 1'b0;
      check("t5_next_fetch_rd_en", imem_rd_en_a, 1);
      check("t5_next_fetch_addr", imem_addr_a, 1);
      tick();
      tick();
      check("t5_latency_op_done_valid", bus_a.instr_valid, 1);
      check("t5_second_word", bus_a.instruction, 16'h2000);
      bus_a.instr_ready = 1'b1;
      auto_a = 1'b1;
      wait_idle_a(100);
      tick();
      check("t5_instr_count", instr_count_a, 4);
      check("t5_done", done_seen_a, 1);

      // Overrun on the small instance
      exp_b.delete();
      for (int i = 0; i < 4; i++) exp_b.push_back(16'h4000);
      bus_b.instr_ready = 1'b1;
      auto_b = 1'b1;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      wait_idle_b(100);
      tick();
      check("t4_err", err_b, 1);
      check("t4_err_code", err_code_b, 2'b10);
      check("t4_instr_count", instr_count_b, 4);
      check("t4_scoreboard_empty", exp_b.size(), 0);
      check("t4_max_fetch_addr", max_addr_b, 3);
      check("t4_final_addr", imem_addr_b, 3);
      check("t4_no_done", done_seen_b, 0);

      // Asynchronous reset while an instruction is on the bus
      std_prog_a();
      bus_a.instr_ready = 1'b1;
      pulse_start_a();
      wait_acc_a(1, 50);
      bus_a.instr_ready = 1'b0;
      wait_valid_a(20);
      check("t6_pre_rst_count", instr_count_a, 1);
      #2 rst = 1'b0;
      #1;
      check("t6_rst_valid", bus_a.instr_valid, 0);
      check("t6_rst_instruction", bus_a.instruction, 16'h0000);
      check("t6_rst_busy", busy_a, 0);
      check("t6_rst_count", instr_count_a, 0);
      check("t6_rst_rd_en", imem_rd_en_a, 0);
      check("t6_rst_addr", imem_addr_a, 0);
      check("t6_rst_err", err_a, 0);
      cnt_a = 0;
      pulse_a = 1'b0;
      bus_a.op_done = 1'b0;
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      std_prog_a();
      bus_a.instr_ready = 1'b1;
      pulse_start_a();
      check("t6_restart_addr", imem_addr_a, 0);
      wait_idle_a(100);
      tick();
      check("t6_rerun_count", instr_count_a, 4);
      check("t6_rerun_done", done_seen_a, 1);
      check("t6_rerun_err", err_a, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
